// File: rtl/gate_test_sequencer_if.sv
// Handshake and datapath bundle between the gate test sequencer and its driver.
// The slave modport is the sequencer side; master is the controlling side.
interface gate_test_sequencer_if;
  logic       start;
  logic       abort;
  logic       dut_a;
  logic       dut_b;
  logic [3:0] dut_y;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] fail_vec;
  logic [2:0] err_count;

  modport master (
    output start, abort, dut_y,
    input  dut_a, dut_b, busy, done, pass, fail_vec, err_count
  );

  modport slave (
    input  start, abort, dut_y,
    output dut_a, dut_b, busy, done, pass, fail_vec, err_count
  );
endinterface

// File: rtl/gate_test_sequencer.sv
// Walks the four input vectors of a 2-input gate datapath, waits for it to settle,
// checks {or, and, not, xor} and reports pass/fail per vector.
module gate_test_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input logic                   clk,
  input logic                   rst_n,
  gate_test_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {StIdle, StDrive, StSettle, StCheck, StDone} state_e;

  localparam logic [3:0] SettleLast = 4'(SETTLE_CYCLES - 1);

  state_e     r_state;
  logic [1:0] r_idx;
  logic [3:0] r_settle_cnt;
  logic       r_dut_a;
  logic       r_dut_b;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [3:0] r_fail_vec;
  logic [2:0] r_err_count;

  logic [3:0] w_exp_y;
  logic       w_mismatch;
  logic [2:0] w_err_next;
  logic [1:0] w_idx_next;

  assign w_exp_y    = {r_dut_a | r_dut_b, r_dut_a & r_dut_b, ~r_dut_a, r_dut_a ^ r_dut_b};
  assign w_mismatch = (bus.dut_y != w_exp_y);
  assign w_err_next = r_err_count + 3'(w_mismatch);
  assign w_idx_next = r_idx + 2'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_idx        <= 2'd0;
      r_settle_cnt <= 4'd0;
      r_dut_a      <= 1'b0;
      r_dut_b      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_fail_vec   <= 4'd0;
      r_err_count  <= 3'd0;
    end else if (r_state != StIdle && bus.abort) begin
      // Abort keeps the accumulated fail_vec/err_count for post-mortem.
      r_state      <= StIdle;
      r_settle_cnt <= 4'd0;
      r_dut_a      <= 1'b0;
      r_dut_b      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (bus.start && !bus.abort) begin
            r_state      <= StDrive;
            r_idx        <= 2'd0;
            r_settle_cnt <= 4'd0;
            r_dut_a      <= 1'b0;
            r_dut_b      <= 1'b0;
            r_busy       <= 1'b1;
            r_pass       <= 1'b0;
            r_fail_vec   <= 4'd0;
            r_err_count  <= 3'd0;
          end
        end
        StDrive: begin
          r_state      <= StSettle;
          r_settle_cnt <= 4'd0;
        end
        StSettle: begin
          if (r_settle_cnt == SettleLast) begin
            r_state <= StCheck;
          end else begin
            r_settle_cnt <= r_settle_cnt + 4'd1;
          end
        end
        StCheck: begin
          if (w_mismatch) begin
            r_fail_vec[r_idx] <= 1'b1;
            r_err_count       <= w_err_next;
          end
          if (r_idx == 2'd3) begin
            r_state <= StDone;
            r_done  <= 1'b1;
            r_pass  <= (w_err_next == 3'd0);
            r_dut_a <= 1'b0;
            r_dut_b <= 1'b0;
          end else begin
            r_state <= StDrive;
            r_idx   <= w_idx_next;
            r_dut_a <= w_idx_next[0];
            r_dut_b <= w_idx_next[1];
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_idx   <= 2'd0;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dut_a     = r_dut_a;
  assign bus.dut_b     = r_dut_b;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.pass      = r_pass;
  assign bus.fail_vec  = r_fail_vec;
  assign bus.err_count = r_err_count;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Scoreboard bench for gate_test_sequencer: runs push expected results, a negedge
// monitor pops them on each done pulse and checks result fields and latency.
module tb_gate_test_sequencer;

  typedef struct {
    int pass;
    int fail_vec;
    int err_count;
    int done_cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   mode;
  int   cyc;
  int   checks;
  int   errors;
  logic prev_done;
  exp_t sb[$];

  gate_test_sequencer_if bus_if ();

  gate_test_sequencer #(.SETTLE_CYCLES(2)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Datapath model; mode 1 = and stuck at 0, mode 2 = not stuck at 1.
  always_comb begin
    bus_if.dut_y = {bus_if.dut_a | bus_if.dut_b, bus_if.dut_a & bus_if.dut_b,
                    ~bus_if.dut_a, bus_if.dut_a ^ bus_if.dut_b};
    if (mode == 1) bus_if.dut_y[2] = 1'b0;
    if (mode == 2) bus_if.dut_y[1] = 1'b1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_done <= 1'b0;
    end else begin
      prev_done <= bus_if.done;
      if (bus_if.done) begin
        chk("done_not_back_to_back", int'(prev_done), 0);
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("pass", int'(bus_if.pass), e.pass);
          chk("fail_vec", int'(bus_if.fail_vec), e.fail_vec);
          chk("err_count", int'(bus_if.err_count), e.err_count);
          chk("done_latency", cyc, e.done_cyc);
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, int'(bus_if.busy), 0);
    chk({tag, "_done"}, int'(bus_if.done), 0);
    chk({tag, "_pass"}, int'(bus_if.pass), 0);
    chk({tag, "_fail_vec"}, int'(bus_if.fail_vec), 0);
    chk({tag, "_err_count"}, int'(bus_if.err_count), 0);
    chk({tag, "_dut_a"}, int'(bus_if.dut_a), 0);
    chk({tag, "_dut_b"}, int'(bus_if.dut_b), 0);
  endtask

  // Full run: drives start, checks vector sequencing, result checked by the monitor.
  task automatic run(input int m, input int e_pass, input int e_fv, input int e_ec,
                     input bit repulse);
    exp_t e;
    @(negedge clk);
    mode = m;
    bus_if.start = 1'b1;
    e.pass = e_pass;
    e.fail_vec = e_fv;
    e.err_count = e_ec;
    e.done_cyc = cyc + 17;
    sb.push_back(e);
    @(negedge clk);
    bus_if.start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      chk("vector", int'({bus_if.dut_b, bus_if.dut_a}), k / 4);
      chk("busy_run", int'(bus_if.busy), 1);
      bus_if.start = (repulse && k == 5);
    end
    @(negedge clk);
    bus_if.start = 1'b0;
    chk("dut_ab_done", int'({bus_if.dut_b, bus_if.dut_a}), 0);
    @(negedge clk);
    chk("busy_after", int'(bus_if.busy), 0);
    chk("pass_hold", int'(bus_if.pass), e_pass);
    chk("fail_vec_hold", int'(bus_if.fail_vec), e_fv);
  endtask

  initial begin
    cyc = 0;
    checks = 0;
    errors = 0;
    mode = 0;
    rst_n = 1'b0;
    bus_if.start = 1'b0;
    bus_if.abort = 1'b0;
    #1;
    check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run(0, 1, 4'b0000, 0, 1'b0);
    run(1, 0, 4'b1000, 1, 1'b0);
    run(2, 0, 4'b1010, 2, 1'b0);
    run(0, 1, 4'b0000, 0, 1'b1);

    // Abort in SETTLE of vector 2 after vector 1 has already mismatched.
    @(negedge clk);
    mode = 2;
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    repeat (9) @(negedge clk);
    bus_if.abort = 1'b1;
    @(negedge clk);
    bus_if.abort = 1'b0;
    chk("abort_busy", int'(bus_if.busy), 0);
    chk("abort_dut_ab", int'({bus_if.dut_b, bus_if.dut_a}), 0);
    chk("abort_done", int'(bus_if.done), 0);
    chk("abort_pass", int'(bus_if.pass), 0);
    chk("abort_fail_vec", int'(bus_if.fail_vec), 4'b0010);
    chk("abort_err_count", int'(bus_if.err_count), 1);
    repeat (20) @(negedge clk);
    run(0, 1, 4'b0000, 0, 1'b0);

    // start and abort together in IDLE are ignored.
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.abort = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    bus_if.abort = 1'b0;
    chk("start_abort_idle_busy", int'(bus_if.busy), 0);
    @(negedge clk);
    chk("start_abort_idle_busy2", int'(bus_if.busy), 0);

    // Asynchronous reset during CHECK of vector 1.
    mode = 0;
    @(negedge clk);
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    repeat (7) @(negedge clk);
    chk("pre_reset_dut_a", int'(bus_if.dut_a), 1);
    chk("pre_reset_busy", int'(bus_if.busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    run(0, 1, 4'b0000, 0, 1'b0);

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_test_sequencer.md
GATE_TEST_SEQUENCER -- requirements
Module: gate_test_sequencer

Interface
REQ-001 The block SHALL have exactly one parameter: SETTLE_CYCLES, default 2, legal range 1..15, giving the number of wait cycles between applying a vector and sampling the datapath.
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all state changes on the rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- start  in  1  request one test run; sampled only in IDLE
- abort  in  1  cancel the run in progress; highest priority
- dut_a  out  1  datapath input x0
- dut_b  out  1  datapath input x1
- dut_y  in  4  datapath results: [0] xor, [1] not x0, [2] and, [3] or
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a run completes
- pass  out  1  result of the last completed run
- fail_vec  out  4  bit i set if vector i mismatched
- err_count  out  3  number of mismatched vectors, 0..4
REQ-003 The clock SHALL be the single clock; reset SHALL be asynchronous and active-low.

Function
REQ-004 The block SHALL implement the following states: IDLE, DRIVE, SETTLE, CHECK and DONE, plus a 2-bit vector index idx and a 4-bit settle counter.
REQ-005 Vector i SHALL be applied as dut_a=idx[0] and dut_b=idx[1]. These values SHALL hold for the whole of DRIVE, SETTLE and CHECK for that vector. Both outputs SHALL be 0 in IDLE and in DONE.
REQ-006 In IDLE, start=1 with abort=0 SHALL cause the following on the next edge:
- go to DRIVE with idx=0
- clear fail_vec and err_count
- clear pass
REQ-007 DRIVE SHALL last exactly 1 cycle, then go to SETTLE.
REQ-008 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then go to CHECK.
REQ-009 CHECK SHALL last exactly 1 cycle and SHALL compare dut_y against the expected value {a|b, a&b, ~a, a^b}, where a=dut_a and b=dut_b.
REQ-010 On a mismatch in CHECK, the block SHALL set fail_vec[idx] and increment err_count.
REQ-011 On leaving CHECK, the block SHALL go to DONE if idx=3; otherwise it SHALL increment idx and go to DRIVE.
REQ-012 DONE SHALL last 1 cycle. During that cycle done=1 and pass=(err_count==0, including the CHECK of vector 3). The next state SHALL be IDLE.
REQ-013 Latency: done SHALL be high in the cycle after the 4*(SETTLE_CYCLES+2)-th rising edge that follows the edge sampling start. For the default, that is after edge 16.
REQ-014 Each vector SHALL occupy exactly SETTLE_CYCLES+2 cycles. There SHALL be no idle gap between vectors.
REQ-015 Outside IDLE, start SHALL be ignored; it SHALL NOT restart or extend a run.
REQ-016 abort=1 in any non-IDLE state, including DONE, SHALL cause the following on the next edge:
- go to IDLE
- drive dut_a=dut_b=0
- suppress done
- leave pass at 0
- retain fail_vec and err_count as accumulated
REQ-017 If start and abort are both high in IDLE, the block SHALL stay in IDLE.
REQ-018 pass, fail_vec and err_count SHALL hold their values in IDLE until the next accepted start.
REQ-019 err_count SHALL always equal the population count of fail_vec and SHALL NOT wrap.
REQ-020 busy SHALL be a registered output equal to (state != IDLE).
REQ-021 done SHALL never be high in two consecutive cycles.

Reset
REQ-022 While rst_n=0, the block SHALL immediately, without a clock, force all of the following:
- state IDLE, idx=0, settle counter 0
- dut_a=0, dut_b=0, busy=0, done=0, pass=0
- fail_vec=0, err_count=0
REQ-023 Reset asserted mid-run SHALL abandon the run with no done pulse.
REQ-024 After rst_n rises, the first start SHALL be accepted on the first rising edge at which it is high.

Verification
REQ-025 Good datapath model, SETTLE_CYCLES=2, one-cycle start pulse:
- busy rises after edge 0
- {dut_b,dut_a} steps through 00, 01, 10, 11, 4 cycles each
- done pulses after edge 16
- pass=1, fail_vec=0000, err_count=0
REQ-026 Model with the and bit stuck at 0 -> fail_vec=1000, err_count=1, pass=0, done after edge 16.
REQ-027 Model with the not bit stuck at 1 -> fail_vec=1010, err_count=2, pass=0.
REQ-028 abort pulsed during the SETTLE of vector 2 -> on the next edge:
- IDLE, busy=0, dut_a=dut_b=0
- no done pulse, pass=0
A following start then completes a full run with pass=1 on the good model.
REQ-029 start re-pulsed during a run is ignored; total run length stays 16 cycles. start and abort high together in IDLE leave busy=0.
REQ-030 rst_n pulsed low asynchronously between clock edges during CHECK of vector 1 -> all outputs 0 before the next edge; no done pulse.
